// File: rtl/multdiv_unit.sv
// Multi-cycle mult/div unit owning HI/LO; optional madd/msub family under MULTDIV_MADD_EN.
// Latency: MULT_CYCLES (mult/madd) or DIV_CYCLES (div) busy cycles, result visible the cycle after Busy falls.
// Backpressure: none accepted; upstream stalls on Start|Busy, and Start/MTHI/MTLO during Busy are dropped.
module multdiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        MULT_Start,
    input  logic [2:0]  MULT_Op,
    input  logic [31:0] MULT_A,
    input  logic [31:0] MULT_B,
    input  logic        MTHI,
    input  logic        MTLO,
    output logic        MULT_Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [63:0]       pend;
    logic              pend_wr;

    logic              is_div;
    logic              sgn;
    logic              op_valid;
    logic              div_by_zero;
    logic [63:0]       mul_a;
    logic [63:0]       mul_b;
    logic [63:0]       product;
    logic [31:0]       dvd;
    logic [31:0]       dvs;
    logic [31:0]       quo;
    logic [31:0]       rem;
    logic [63:0]       result;

    always_comb begin
        is_div      = (MULT_Op[2:1] == 2'b01);
        sgn         = ~MULT_Op[0];
`ifdef MULTDIV_MADD_EN
        op_valid    = 1'b1;
`else
        op_valid    = ~MULT_Op[2];
`endif
        div_by_zero = is_div && (MULT_B == '0);

        // Sign-extending to 64 bits lets one unsigned multiplier serve both signednesses.
        mul_a   = {{32{sgn & MULT_A[31]}}, MULT_A};
        mul_b   = {{32{sgn & MULT_B[31]}}, MULT_B};
        product = mul_a * mul_b;

        // Signed divide runs on magnitudes; 0x80000000 magnitude is exact as unsigned.
        dvd = (sgn && MULT_A[31]) ? -MULT_A : MULT_A;
        dvs = (sgn && MULT_B[31]) ? -MULT_B : MULT_B;
        quo = '0;
        rem = '0;
        if (dvs != '0) begin
            quo = dvd / dvs;
            rem = dvd % dvs;
        end
        if (sgn && (MULT_A[31] ^ MULT_B[31])) quo = -quo;
        if (sgn && MULT_A[31])                rem = -rem;

        result = is_div ? {rem, quo} : product;
`ifdef MULTDIV_MADD_EN
        if (MULT_Op[2]) result = MULT_Op[1] ? ({HI, LO} - product) : ({HI, LO} + product);
`endif
    end

    assign MULT_Busy = (state == BUSY);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            cnt     <= '0;
            pend    <= '0;
            pend_wr <= 1'b0;
            HI      <= '0;
            LO      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (MULT_Start) begin
                        if (op_valid) begin
                            pend    <= result;
                            pend_wr <= ~div_by_zero;
                            cnt     <= is_div ? DIV_LOAD : MULT_LOAD;
                            state   <= BUSY;
                        end
                    end else begin
                        if (MTHI) HI <= MULT_A;
                        if (MTLO) LO <= MULT_A;
                    end
                end
                BUSY: begin
                    if (cnt == CNT_W'(1)) begin
                        if (pend_wr) {HI, LO} <= pend;
                        pend_wr <= 1'b0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Bench for multdiv_unit: directed vector table, hand corner sequences, random ops vs arithmetic model.
module tb_multdiv_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        MULT_Start;
    logic [2:0]  MULT_Op;
    logic [31:0] MULT_A;
    logic [31:0] MULT_B;
    logic        MTHI;
    logic        MTLO;
    logic        MULT_Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    multdiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset_n(reset_n), .MULT_Start(MULT_Start), .MULT_Op(MULT_Op),
        .MULT_A(MULT_A), .MULT_B(MULT_B), .MTHI(MTHI), .MTLO(MTLO),
        .MULT_Busy(MULT_Busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Architectural effect of one operation on the model registers; returns expected busy cycles.
    function automatic int model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [63:0] hl;
        longint q;
        longint r;
        hl = {m_hi, m_lo};
        if (op[2]) begin
`ifdef MULTDIV_MADD_EN
            if (op[0]) p = {32'b0, a} * {32'b0, b};
            else       p = longint'($signed(a)) * longint'($signed(b));
            hl = op[1] ? hl - p : hl + p;
            {m_hi, m_lo} = hl;
            return MC;
`else
            return 0;
`endif
        end
        if (op[1]) begin
            if (b != 0) begin
                if (op[0]) begin
                    q = longint'({32'b0, a}) / longint'({32'b0, b});
                    r = longint'({32'b0, a}) % longint'({32'b0, b});
                end else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                end
                m_lo = q[31:0];
                m_hi = r[31:0];
            end
            return DC;
        end
        if (op[0]) p = {32'b0, a} * {32'b0, b};
        else       p = longint'($signed(a)) * longint'($signed(b));
        {m_hi, m_lo} = p;
        return MC;
    endfunction

    // Called at a negedge while idle; returns at the first negedge with Busy low.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inj, input logic with_mt, input string nm);
        logic [31:0] h0;
        logic [31:0] l0;
        logic        hold_ok;
        int          exp_n;
        int          n;
        h0 = HI;
        l0 = LO;
        hold_ok = 1'b1;
        exp_n = model(op, a, b);
        MULT_Start = 1'b1; MULT_Op = op; MULT_A = a; MULT_B = b;
        MTHI = with_mt; MTLO = with_mt;
        @(negedge clk);
        MULT_Start = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
        MULT_A = $urandom; MULT_B = $urandom;
        n = 0;
        while (MULT_Busy && n < 64) begin
            n++;
            if (HI !== h0 || LO !== l0) hold_ok = 1'b0;
            if (n == inj) begin
                MULT_Start = 1'b1; MULT_Op = 3'b010; MTHI = 1'b1; MTLO = 1'b1;
            end
            @(negedge clk);
            MULT_Start = 1'b0; MTHI = 1'b0; MTLO = 1'b0;
        end
        check({nm, " busy_cycles"}, 32'(n), 32'(exp_n));
        check({nm, " hold_while_busy"}, {31'b0, hold_ok}, 32'd1);
        check({nm, " hi"}, HI, m_hi);
        check({nm, " lo"}, LO, m_lo);
    endtask

    task automatic do_mt(input logic hi_en, input logic lo_en, input logic [31:0] a, input string nm);
        MTHI = hi_en; MTLO = lo_en; MULT_A = a;
        if (hi_en) m_hi = a;
        if (lo_en) m_lo = a;
        @(negedge clk);
        MTHI = 1'b0; MTLO = 1'b0; MULT_A = $urandom;
        check({nm, " busy"}, {31'b0, MULT_Busy}, 32'd0);
        check({nm, " hi"}, HI, m_hi);
        check({nm, " lo"}, LO, m_lo);
    endtask

    typedef struct {
        logic        mt;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        hi_en;
        logic        lo_en;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic        rst_ok;
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0]  = '{1'b0, 3'd0, 32'hFFFFFFFD, 32'd7,        1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1]  = '{1'b0, 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 32'hFFFFFFFE, 32'h00000001};
        vecs[2]  = '{1'b0, 3'd2, 32'hFFFFFFF9, 32'd2,        1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{1'b0, 3'd3, 32'd7,        32'd0,        1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{1'b0, 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h00000000, 32'h80000000};
        vecs[5]  = '{1'b0, 3'd3, 32'hFFFFFFFF, 32'd16,       1'b0, 1'b0, 32'h0000000F, 32'h0FFFFFFF};
        vecs[6]  = '{1'b0, 3'd2, 32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFD};
        vecs[7]  = '{1'b1, 3'd0, 32'h12345678, 32'd0,        1'b1, 1'b0, 32'h12345678, 32'hFFFFFFFD};
        vecs[8]  = '{1'b1, 3'd0, 32'h00000000, 32'd0,        1'b1, 1'b1, 32'h00000000, 32'h00000000};
`ifdef MULTDIV_MADD_EN
        vecs[9]  = '{1'b0, 3'd4, 32'd2,        32'd3,        1'b0, 1'b0, 32'h00000000, 32'h00000006};
        vecs[10] = '{1'b0, 3'd4, 32'd2,        32'd3,        1'b0, 1'b0, 32'h00000000, 32'h0000000C};
        vecs[11] = '{1'b0, 3'd6, 32'd4,        32'd4,        1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFC};
`else
        vecs[9]  = '{1'b0, 3'd4, 32'd2,        32'd3,        1'b0, 1'b0, 32'h00000000, 32'h00000000};
        vecs[10] = '{1'b0, 3'd7, 32'd9,        32'd9,        1'b0, 1'b0, 32'h00000000, 32'h00000000};
        vecs[11] = '{1'b1, 3'd0, 32'd5,        32'd0,        1'b0, 1'b1, 32'h00000000, 32'h00000005};
`endif

        reset_n = 1'b0; MULT_Start = 1'b0; MULT_Op = '0;
        MULT_A = 32'hA5A5A5A5; MULT_B = 32'h5A5A5A5A; MTHI = 1'b0; MTLO = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", {31'b0, MULT_Busy}, 32'd0);
        check("reset hi", HI, 32'd0);
        check("reset lo", LO, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].mt) do_mt(vecs[i].hi_en, vecs[i].lo_en, vecs[i].a, $sformatf("vec%0d", i));
            else            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 0, 1'b0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d table_hi", i), HI, vecs[i].exp_hi);
            check($sformatf("vec%0d table_lo", i), LO, vecs[i].exp_lo);
        end

        // Start/MTHI/MTLO pulsed mid-operation must neither stretch Busy nor touch HI/LO.
        do_op(3'd0, 32'd3, 32'd5, 2, 1'b0, "inject_busy");
        check("inject_busy lo_const", LO, 32'd15);
        // Start together with MTHI/MTLO in IDLE: the operation wins.
        do_op(3'd1, 32'd6, 32'd7, 0, 1'b1, "start_wins");
        check("start_wins lo_const", LO, 32'd42);

        // Asynchronous reset in the 4th busy cycle of a divide.
        do_mt(1'b1, 1'b1, 32'h0BADF00D, "pre_reset_mt");
        MULT_Start = 1'b1; MULT_Op = 3'd3; MULT_A = 32'd100; MULT_B = 32'd7;
        @(negedge clk);
        MULT_Start = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset busy", {31'b0, MULT_Busy}, 32'd0);
        check("midreset hi", HI, 32'd0);
        check("midreset lo", LO, 32'd0);
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        reset_n = 1'b1;
        rst_ok = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (MULT_Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) rst_ok = 1'b0;
        end
        check("midreset no_late_commit", {31'b0, rst_ok}, 32'd1);

        for (int i = 0; i < 60; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 1) == 0) begin
                ra = ra >> $urandom_range(0, 31);
                rb = rb >> $urandom_range(0, 31);
            end
            if ($urandom_range(0, 4) == 0) begin
                do_mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $sformatf("rnd%0d_mt", i));
            end else begin
                rop = 3'($urandom_range(0, 7));
                do_op(rop, ra, rb, 0, 1'b0, $sformatf("rnd%0d_op%0d", i, rop));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
